// File: rtl/pc_register_if.sv
// -----------------------------------------------------------------------------
// pc_register_if
//   Bundles the fetch-PC register's redirect/prediction inputs and its fetch
//   request outputs.
//
//   Fetch handshake: a fetch group is transferred on a clk edge where
//   PCR_valid_o and IF_allowin_i are both high. PCR_VAddr_o and
//   PCR_needDelaySlot_o stay stable while PCR_valid_o is high and
//   IF_allowin_i is low. CP0/BR redirects are commands, not handshakes. They
//   take effect on the next edge whatever the state of IF_allowin_i.
//
//   Modports:
//     master : surrounding pipeline (drives redirects, BTB result, allowin)
//     slave  : pc_register (drives PCR_* outputs)
// -----------------------------------------------------------------------------
interface pc_register_if;
  logic        IF_allowin_i;
  logic        CP0_flush_i;
  logic [31:0] CP0_target_i;
  logic        BR_redirect_i;
  logic [31:0] BR_target_i;
  logic        BR_needDelaySlot_i;
  logic [31:0] BR_slotVAddr_i;
  logic        BTB_taken_i;
  logic [31:0] BTB_target_i;
  logic        BTB_slotInNext_i;
  logic [31:0] PCR_VAddr_o;
  logic [31:0] PCR_lastVAddr_o;
  logic        PCR_needDelaySlot_o;
  logic        PCR_valid_o;

  modport master (
    output IF_allowin_i, CP0_flush_i, CP0_target_i,
           BR_redirect_i, BR_target_i, BR_needDelaySlot_i, BR_slotVAddr_i,
           BTB_taken_i, BTB_target_i, BTB_slotInNext_i,
    input  PCR_VAddr_o, PCR_lastVAddr_o, PCR_needDelaySlot_o, PCR_valid_o
  );

  modport slave (
    input  IF_allowin_i, CP0_flush_i, CP0_target_i,
           BR_redirect_i, BR_target_i, BR_needDelaySlot_i, BR_slotVAddr_i,
           BTB_taken_i, BTB_target_i, BTB_slotInNext_i,
    output PCR_VAddr_o, PCR_lastVAddr_o, PCR_needDelaySlot_o, PCR_valid_o
  );
endinterface

// File: rtl/pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
//   Fetch-PC register for the IF stage. It holds the current fetch-group
//   address (pc_q), the pending delay-slot group address (last_q) and the
//   delay-slot state. The next PC is chosen from these sources, highest
//   priority first: CP0 flush, backend mispredict redirect, stall, delay-slot
//   drain, BTB taken prediction, and the sequential group increment.
//
//   Ports:
//     clk   : clock
//     rst_n : asynchronous active-low reset
//     bus   : pc_register_if.slave (redirect inputs and fetch outputs)
//
//   Every output comes straight from a flop. The FSM state is visible
//   directly as PCR_needDelaySlot_o (DSLOT = 1).
// -----------------------------------------------------------------------------
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_register_if.slave       bus
);

  typedef enum logic {NORMAL = 1'b0, DSLOT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] last_q, last_d;
  logic        valid_q;
  logic [27:0] pc_group_inc;
  logic [31:0] pc_seq;

  // The next sequential group is aligned to 16 bytes. It wraps to 0 past
  // the top of the address space.
  assign pc_group_inc = pc_q[31:4] + 28'd1;
  assign pc_seq       = {pc_group_inc, 4'b0000};

  // Fetching starts one edge after reset release. The edge that raises valid
  // must not advance pc_q, so RESET_PC is the first address presented.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    if (bus.CP0_flush_i) begin
      pc_d    = bus.CP0_target_i;
      state_d = NORMAL;
    end else if (bus.BR_redirect_i) begin
      pc_d = bus.BR_target_i;
      if (bus.BR_needDelaySlot_i) begin
        last_d  = bus.BR_slotVAddr_i;
        state_d = DSLOT;
      end else begin
        state_d = NORMAL;
      end
    end else if (!bus.IF_allowin_i || !valid_q) begin
      // stall: hold everything
    end else if (state_q == DSLOT) begin
      // The delay-slot group was just accepted. pc_q already holds the
      // target, so it is fetched next. BTB output is ignored here.
      state_d = NORMAL;
    end else if (bus.BTB_taken_i) begin
      pc_d = bus.BTB_target_i;
      if (bus.BTB_slotInNext_i) begin
        last_d  = pc_seq;
        state_d = DSLOT;
      end
    end else begin
      pc_d = pc_seq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      pc_q    <= RESET_PC;
      last_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      valid_q <= 1'b1;
    end
  end

  assign bus.PCR_VAddr_o         = pc_q;
  assign bus.PCR_lastVAddr_o     = last_q;
  assign bus.PCR_needDelaySlot_o = (state_q == DSLOT);
  assign bus.PCR_valid_o         = valid_q;

endmodule

// File: tb/tb_pc_register.sv
// -----------------------------------------------------------------------------
// tb_pc_register
//   Directed test of pc_register: reset release, sequential fetch, BTB taken
//   with and without a next-group delay slot, stall while in DSLOT,
//   CP0-over-BR priority, redirects while in DSLOT, address wrap, and reset
//   asserted while in DSLOT.
// -----------------------------------------------------------------------------
module tb_pc_register;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  pc_register_if bus ();

  pc_register #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CP0_flush_i        = 1'b0;
    bus.CP0_target_i       = 32'h0;
    bus.BR_redirect_i      = 1'b0;
    bus.BR_target_i        = 32'h0;
    bus.BR_needDelaySlot_i = 1'b0;
    bus.BR_slotVAddr_i     = 32'h0;
    bus.BTB_taken_i        = 1'b0;
    bus.BTB_target_i       = 32'h0;
    bus.BTB_slotInNext_i   = 1'b0;
  endtask

  task automatic flush_to(input logic [31:0] target);
    bus.CP0_flush_i  = 1'b1;
    bus.CP0_target_i = target;
    step();
    idle_inputs();
  endtask

  task automatic btb(input logic [31:0] target, input logic slot_next);
    bus.BTB_taken_i      = 1'b1;
    bus.BTB_target_i     = target;
    bus.BTB_slotInNext_i = slot_next;
    step();
    idle_inputs();
  endtask

  task automatic expect_all(input string tag, input logic [31:0] va,
                            input logic [31:0] last, input logic ds,
                            input logic vld);
    check({tag, ".va"},    bus.PCR_VAddr_o, va);
    check({tag, ".last"},  bus.PCR_lastVAddr_o, last);
    check({tag, ".dslot"}, {31'h0, bus.PCR_needDelaySlot_o}, {31'h0, ds});
    check({tag, ".valid"}, {31'h0, bus.PCR_valid_o}, {31'h0, vld});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    idle_inputs();
    bus.IF_allowin_i = 1'b1;

    // reset state
    #12;
    expect_all("reset", 32'hBFC0_0000, 32'h0, 1'b0, 1'b0);

    // release away from the edge; first fetch presents RESET_PC
    rst_n = 1'b1;
    step();
    expect_all("first", 32'hBFC0_0000, 32'h0, 1'b0, 1'b1);
    step();
    check("seq1", bus.PCR_VAddr_o, 32'hBFC0_0010);
    step();
    check("seq2", bus.PCR_VAddr_o, 32'hBFC0_0020);

    // BTB taken, delay slot within the group
    flush_to(32'hBFC0_0010);
    check("flush", bus.PCR_VAddr_o, 32'hBFC0_0010);
    btb(32'h8000_1238, 1'b0);
    expect_all("btb", 32'h8000_1238, 32'h0, 1'b0, 1'b1);
    step();
    check("btb_seq", bus.PCR_VAddr_o, 32'h8000_1240);

    // BTB taken, delay slot in the next group
    flush_to(32'hBFC0_0010);
    btb(32'h8000_2000, 1'b1);
    expect_all("ds_enter", 32'h8000_2000, 32'hBFC0_0020, 1'b1, 1'b1);
    bus.IF_allowin_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_all($sformatf("ds_stall%0d", i), 32'h8000_2000, 32'hBFC0_0020,
                 1'b1, 1'b1);
    end
    // BTB output must be ignored while draining the slot
    bus.IF_allowin_i = 1'b1;
    btb(32'h1234_5670, 1'b1);
    expect_all("ds_exit", 32'h8000_2000, 32'hBFC0_0020, 1'b0, 1'b1);
    step();
    check("ds_after", bus.PCR_VAddr_o, 32'h8000_2010);

    // CP0 beats BR in the same cycle, even while stalled
    bus.IF_allowin_i       = 1'b0;
    bus.CP0_flush_i        = 1'b1;
    bus.CP0_target_i       = 32'hBFC0_0380;
    bus.BR_redirect_i      = 1'b1;
    bus.BR_target_i        = 32'h8000_0000;
    bus.BR_needDelaySlot_i = 1'b1;
    bus.BR_slotVAddr_i     = 32'h1111_1110;
    step();
    idle_inputs();
    expect_all("cp0_wins", 32'hBFC0_0380, 32'hBFC0_0020, 1'b0, 1'b1);

    // BR redirect while in DSLOT replaces the pending slot
    bus.IF_allowin_i = 1'b1;
    btb(32'h8000_3000, 1'b1);
    expect_all("ds2", 32'h8000_3000, 32'hBFC0_0390, 1'b1, 1'b1);
    bus.BR_redirect_i      = 1'b1;
    bus.BR_target_i        = 32'h8000_4000;
    bus.BR_needDelaySlot_i = 1'b1;
    bus.BR_slotVAddr_i     = 32'h8000_3FFC;
    step();
    idle_inputs();
    expect_all("br_ds", 32'h8000_4000, 32'h8000_3FFC, 1'b1, 1'b1);

    // BR redirect without a slot cancels DSLOT; low bits are kept as sent
    bus.BR_redirect_i = 1'b1;
    bus.BR_target_i   = 32'h8000_5004;
    step();
    idle_inputs();
    expect_all("br_cancel", 32'h8000_5004, 32'h8000_3FFC, 1'b0, 1'b1);
    step();
    check("br_seq", bus.PCR_VAddr_o, 32'h8000_5010);

    // wrap at the top of the address space
    flush_to(32'hFFFF_FFF0);
    check("wrap_pre", bus.PCR_VAddr_o, 32'hFFFF_FFF0);
    step();
    check("wrap", bus.PCR_VAddr_o, 32'h0000_0000);

    // reset while in DSLOT
    btb(32'h4000_0000, 1'b1);
    expect_all("ds3", 32'h4000_0000, 32'h0000_0010, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all("rst_mid", 32'hBFC0_0000, 32'h0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    step();
    expect_all("rerelease", 32'hBFC0_0000, 32'h0, 1'b0, 1'b1);
    step();
    check("reseq", bus.PCR_VAddr_o, 32'hBFC0_0010);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
